// File: rtl/conv_tap_mac_pkg.sv
// Shared types and constant helpers for the convolution tap MAC.
// The FSM encoding, the accumulator width and the round/saturate constants live here.
package conv_tap_mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MAC   = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Wide enough to hold any constant derived from WIDTH/FBITS up to 64 bits.
  typedef logic signed [127:0] wide_t;

  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic wide_t round_const(input int f);
    return (f > 0) ? (wide_t'(1) <<< (f - 1)) : wide_t'(0);
  endfunction

  function automatic wide_t sat_max(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/conv_tap_mac_fx_round_sat.sv
// Bias add, round-half-up and saturation of the wide accumulator to one result word.
// Purely combinational; the caller registers the result.
module fx_round_sat
  import conv_tap_mac_pkg::*;
#(
  parameter int IN_W  = 69,
  parameter int WIDTH = 32,
  parameter int FBITS = 24
) (
  input  logic signed [IN_W-1:0]  acc,
  input  logic signed [WIDTH-1:0] bias,
  output logic signed [WIDTH-1:0] result
);

  // Two guard bits so acc + bias + rounding constant cannot wrap.
  localparam int SUM_W = IN_W + 2;

  localparam logic signed [SUM_W-1:0] RND   = SUM_W'(round_const(FBITS));
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(sat_max(WIDTH));
  localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(sat_min(WIDTH));

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;

  always_comb begin
    sum     = SUM_W'(acc) + (SUM_W'(bias) <<< FBITS) + RND;
    shifted = sum >>> FBITS;
    if (shifted > MAX_V) begin
      result = WIDTH'(MAX_V);
    end else if (shifted < MIN_V) begin
      result = WIDTH'(MIN_V);
    end else begin
      result = shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/conv_tap_mac.sv
// One-output FIR tap MAC: snapshots the window, walks the weight ROM, rounds and saturates.
//
// state | meaning
// IDLE  | waiting for start; start_ready high
// FETCH | w_addr = 0 presented to the weight ROM
// MAC   | accumulate shadow_tap[k] * w_data, one tap per cycle
// FINAL | bias add, round, saturate into out_data
// DONE  | out_valid held until out_ready
module conv_tap_mac
  import conv_tap_mac_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FBITS = 24,
  parameter int N_TAP = 31
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_TAP*WIDTH-1:0]         taps_flat,
  input  logic signed [WIDTH-1:0]        bias,
  input  logic                           start,
  output logic                           start_ready,
  output logic [addr_width(N_TAP)-1:0]   w_addr,
  input  logic signed [WIDTH-1:0]        w_data,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int AW    = addr_width(N_TAP);
  localparam int ACC_W = acc_width(WIDTH, N_TAP);
  localparam logic [AW-1:0] LAST = AW'(N_TAP - 1);

  state_t                    state;
  logic signed [WIDTH-1:0]   shadow_tap [N_TAP];
  logic signed [WIDTH-1:0]   shadow_bias;
  logic signed [ACC_W-1:0]   acc;
  logic [AW-1:0]             mac_idx;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   rnd_out;

  assign prod = shadow_tap[mac_idx] * w_data;

  fx_round_sat #(
    .IN_W  (ACC_W),
    .WIDTH (WIDTH),
    .FBITS (FBITS)
  ) u_round_sat (
    .acc    (acc),
    .bias   (shadow_bias),
    .result (rnd_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      w_addr      <= '0;
      start_ready <= 1'b1;
      mac_idx     <= '0;
      shadow_bias <= '0;
      for (int k = 0; k < N_TAP; k++) shadow_tap[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && start_ready) begin
            for (int k = 0; k < N_TAP; k++) shadow_tap[k] <= taps_flat[k*WIDTH +: WIDTH];
            shadow_bias <= bias;
            acc         <= '0;
            w_addr      <= '0;
            mac_idx     <= '0;
            start_ready <= 1'b0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          w_addr <= (N_TAP > 1) ? AW'(1) : '0;
          state  <= S_MAC;
        end
        S_MAC: begin
          // w_data here belongs to tap mac_idx; w_addr already runs one tap ahead.
          acc <= acc + ACC_W'(prod);
          if (mac_idx == LAST) begin
            mac_idx <= '0;
            w_addr  <= '0;
            state   <= S_FINAL;
          end else begin
            mac_idx <= mac_idx + AW'(1);
            w_addr  <= (w_addr == LAST) ? '0 : w_addr + AW'(1);
          end
        end
        S_FINAL: begin
          out_data  <= rnd_out;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          out_valid   <= 1'b0;
          start_ready <= 1'b1;
          w_addr      <= '0;
        end
      endcase
    end
  end

endmodule
